// File: rtl/video_sig_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_sig_gen
// Purpose  : Raster timing generator. Free-running pixel/line counters with
//            combinational sync, active-draw, new-frame and frame-count decodes.
//            Optional frame counter enabled by VIDEO_SIG_GEN_FRAME_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module video_sig_gen #(
    parameter int ACTIVE_H      = 1280,
    parameter int H_FRONT_PORCH = 110,
    parameter int H_SYNC_WIDTH  = 40,
    parameter int H_BACK_PORCH  = 220,
    parameter int ACTIVE_V      = 720,
    parameter int V_FRONT_PORCH = 5,
    parameter int V_SYNC_WIDTH  = 5,
    parameter int V_BACK_PORCH  = 20,
    parameter int FPS           = 60
) (
    input  logic        clk_pixel_in,
    input  logic        rst_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        ad_out,
    output logic        nf_out,
    output logic [5:0]  fc_out
);

    localparam int TOTAL_H = ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int TOTAL_V = ACTIVE_V + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    localparam logic [10:0] c_h_last     = 11'(TOTAL_H - 1);
    localparam logic [10:0] c_h_active   = 11'(ACTIVE_H);
    localparam logic [10:0] c_hs_start   = 11'(ACTIVE_H + H_FRONT_PORCH);
    localparam logic [10:0] c_hs_end     = 11'(ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [9:0]  c_v_last     = 10'(TOTAL_V - 1);
    localparam logic [9:0]  c_v_active   = 10'(ACTIVE_V);
    localparam logic [9:0]  c_vs_start   = 10'(ACTIVE_V + V_FRONT_PORCH);
    localparam logic [9:0]  c_vs_end     = 10'(ACTIVE_V + V_FRONT_PORCH + V_SYNC_WIDTH);

    logic [10:0] r_hcount;
    logic [9:0]  r_vcount;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_new_frame;
    logic [5:0]  w_frame_count;

    assign w_h_last    = (r_hcount == c_h_last);
    assign w_v_last    = (r_vcount == c_v_last);
    assign w_new_frame = (r_hcount == c_h_active) && (r_vcount == c_v_active);

    always_ff @(posedge clk_pixel_in) begin
        if (!rst_in) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_h_last) begin
            r_hcount <= '0;
            r_vcount <= w_v_last ? '0 : r_vcount + 10'd1;
        end else begin
            r_hcount <= r_hcount + 11'd1;
        end
    end

`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
    localparam logic [5:0] c_fc_last = 6'(FPS - 1);

    logic [5:0] r_frame_count;

    always_ff @(posedge clk_pixel_in) begin
        if (!rst_in) begin
            r_frame_count <= '0;
        end else if (w_new_frame) begin
            r_frame_count <= (r_frame_count == c_fc_last) ? '0 : r_frame_count + 6'd1;
        end
    end

    assign w_frame_count = r_frame_count;
`else
    // FPS has no effect without the counter; folded to zero.
    assign w_frame_count = 6'(FPS) & 6'd0;
`endif

    // Every output is held low while reset is asserted, including ad_out.
    assign hcount_out = rst_in ? r_hcount : '0;
    assign vcount_out = rst_in ? r_vcount : '0;
    assign ad_out     = rst_in && (r_hcount < c_h_active) && (r_vcount < c_v_active);
    assign hs_out     = rst_in && (r_hcount >= c_hs_start) && (r_hcount < c_hs_end);
    assign vs_out     = rst_in && (r_vcount >= c_vs_start) && (r_vcount < c_vs_end);
    assign nf_out     = rst_in && w_new_frame;
    assign fc_out     = rst_in ? w_frame_count : '0;

endmodule
`default_nettype wire

// File: tb/tb_video_sig_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_sig_gen
// Purpose  : Scoreboard bench for video_sig_gen: a small-geometry instance and
//            a default-geometry instance, each checked every pixel clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_sig_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        ad;
        logic        nf;
        logic [5:0]  fc;
    } obs_t;

    typedef struct {
        int ah; int hs_lo; int hs_hi; int th;
        int av; int vs_lo; int vs_hi; int tv;
    } geom_t;

    logic        clk;
    logic        rst_s, rst_d;
    logic [10:0] h_s, h_d;
    logic [9:0]  v_s, v_d;
    logic        hs_s, hs_d, vs_s, vs_d, ad_s, ad_d, nf_s, nf_d;
    logic [5:0]  fc_s, fc_d;
    obs_t        act_s, act_d;

    int   total = 0;
    int   bad   = 0;
    obs_t q_s[$];
    obs_t q_d[$];

    int    pos  [2];
    int    fcm  [2];
    logic  prev [2];
    geom_t g    [2];

    video_sig_gen #(
        .ACTIVE_H(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(2), .H_BACK_PORCH(2),
        .ACTIVE_V(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1), .V_BACK_PORCH(1),
        .FPS(60)
    ) dut_small (
        .clk_pixel_in(clk), .rst_in(rst_s),
        .hcount_out(h_s), .vcount_out(v_s), .hs_out(hs_s), .vs_out(vs_s),
        .ad_out(ad_s), .nf_out(nf_s), .fc_out(fc_s)
    );

    video_sig_gen dut_dflt (
        .clk_pixel_in(clk), .rst_in(rst_d),
        .hcount_out(h_d), .vcount_out(v_d), .hs_out(hs_d), .vs_out(vs_d),
        .ad_out(ad_d), .nf_out(nf_d), .fc_out(fc_d)
    );

    assign act_s = {h_s, v_s, hs_s, vs_s, ad_s, nf_s, fc_s};
    assign act_d = {h_d, v_d, hs_d, vs_d, ad_d, nf_d, fc_d};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t expect_of(input int p, input int f, input logic run, input geom_t gg);
        obs_t e;
        int   h;
        int   v;
        e = '0;
        if (run) begin
            h    = p % gg.th;
            v    = p / gg.th;
            e.h  = 11'(h);
            e.v  = 10'(v);
            e.ad = (h < gg.ah) && (v < gg.av);
            e.hs = (h >= gg.hs_lo) && (h <= gg.hs_hi);
            e.vs = (v >= gg.vs_lo) && (v <= gg.vs_hi);
            e.nf = (h == gg.ah) && (v == gg.av);
`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
            e.fc = 6'(f);
`else
            e.fc = 6'(f) & 6'd0;
`endif
        end
        return e;
    endfunction

    // One pixel clock: advance both models over the edge, then apply new resets.
    task automatic step(input logic r0, input logic r1);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!prev[i]) begin
                pos[i] = 0;
                fcm[i] = 0;
            end else begin
                if (pos[i] == g[i].av * g[i].th + g[i].ah) fcm[i] = (fcm[i] + 1) % 60;
                pos[i] = (pos[i] + 1) % (g[i].th * g[i].tv);
            end
        end
        #1;
        rst_s   = r0;
        rst_d   = r1;
        prev[0] = r0;
        prev[1] = r1;
        q_s.push_back(expect_of(pos[0], fcm[0], r0, g[0]));
        q_d.push_back(expect_of(pos[1], fcm[1], r1, g[1]));
    endtask

    task automatic check(input string name, input obs_t a, input obs_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got h=%0d v=%0d hs=%0b vs=%0b ad=%0b nf=%0b fc=%0d, want h=%0d v=%0d hs=%0b vs=%0b ad=%0b nf=%0b fc=%0d",
                     name, a.h, a.v, a.hs, a.vs, a.ad, a.nf, a.fc,
                     e.h, e.v, e.hs, e.vs, e.ad, e.nf, e.fc);
        end
    endtask

    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                check("small", act_s, e);
            end
            if (q_d.size() > 0) begin
                e = q_d.pop_front();
                check("dflt", act_d, e);
            end
        end
    end

    initial begin
        g[0] = '{ah: 8,    hs_lo: 10,   hs_hi: 11,   th: 14,
                 av: 4,    vs_lo: 5,    vs_hi: 5,    tv: 7};
        g[1] = '{ah: 1280, hs_lo: 1390, hs_hi: 1429, th: 1650,
                 av: 720,  vs_lo: 725,  vs_hi: 729,  tv: 750};
        for (int i = 0; i < 2; i++) begin
            pos[i]  = 0;
            fcm[i]  = 0;
            prev[i] = 1'b0;
        end
        rst_s = 1'b0;
        rst_d = 1'b0;

        repeat (3) step(1'b0, 1'b0);
        // Long run: ~72 small frames (fc wraps) and four default lines.
        for (int n = 0; n < 8000 && pos[1] != 4 * 1650 + 500; n++) step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        for (int n = 0; n < 200 && pos[0] != 2 * 14 + 5; n++) step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        repeat (150) step(1'b1, 1'b1);

        @(negedge clk);
        @(negedge clk);
        if (q_s.size() != 0 || q_d.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d/%0d queued, want 0/0", q_s.size(), q_d.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_sig_gen.md
VIDEO_SIG_GEN -- requirements
Module: video_sig_gen

Interface
REQ-001 The block SHALL have parameter ACTIVE_H, default 1280, meaning active pixels per line.
REQ-002 The block SHALL have parameter H_FRONT_PORCH, default 110, meaning blank pixels between active end and hsync start.
REQ-003 The block SHALL have parameter H_SYNC_WIDTH, default 40, meaning hsync width in pixels.
REQ-004 The block SHALL have parameter H_BACK_PORCH, default 220, meaning blank pixels after hsync.
REQ-005 The block SHALL have parameter ACTIVE_V, default 720, meaning active lines per frame.
REQ-006 The block SHALL have parameter V_FRONT_PORCH, default 5, meaning blank lines between active end and vsync start.
REQ-007 The block SHALL have parameter V_SYNC_WIDTH, default 5, meaning vsync width in lines.
REQ-008 The block SHALL have parameter V_BACK_PORCH, default 20, meaning blank lines after vsync.
REQ-009 The block SHALL have parameter FPS, default 60, meaning frame counter modulus.
REQ-010 The block SHALL have port clk_pixel_in, input, 1, the pixel clock; one clock only.
REQ-011 The block SHALL have port rst_in, input, 1, reset, synchronous, active-low.
REQ-012 The block SHALL have port hcount_out, output, 11, horizontal pixel index.
REQ-013 The block SHALL have port vcount_out, output, 10, vertical line index.
REQ-014 The block SHALL have port hs_out, output, 1, horizontal sync, active-high.
REQ-015 The block SHALL have port vs_out, output, 1, vertical sync, active-high.
REQ-016 The block SHALL have port ad_out, output, 1, active-draw flag.
REQ-017 The block SHALL have port nf_out, output, 1, single-cycle new-frame pulse.
REQ-018 The block SHALL have port fc_out, output, 6, frame counter.

Function
REQ-019 Derived totals: TOTAL_H = sum of the four H parameters (1650 default); TOTAL_V = sum of the four V parameters (750 default).
REQ-020 hcount_out SHALL increment by 1 each clock and wrap from TOTAL_H-1 to 0.
REQ-021 vcount_out SHALL increment by 1 on the cycle hcount_out wraps, and SHALL wrap from TOTAL_V-1 to 0 on the cycle both counters are at their maximum.
REQ-022 ad_out SHALL be 1 iff hcount_out < ACTIVE_H and vcount_out < ACTIVE_V, in the same cycle as the counts.
REQ-023 hs_out SHALL be 1 iff ACTIVE_H+H_FRONT_PORCH <= hcount_out < ACTIVE_H+H_FRONT_PORCH+H_SYNC_WIDTH (1390..1429 default), same cycle as the counts.
REQ-024 vs_out SHALL be 1 iff ACTIVE_V+V_FRONT_PORCH <= vcount_out < ACTIVE_V+V_FRONT_PORCH+V_SYNC_WIDTH (725..729 default), for every pixel of those lines.
REQ-025 nf_out SHALL be 1 for exactly one cycle per frame: the cycle where hcount_out==ACTIVE_H and vcount_out==ACTIVE_V.
REQ-026 fc_out SHALL increment on each cycle nf_out is 1, wrap from FPS-1 to 0, and show the new value from the cycle after the pulse.
REQ-027 All outputs SHALL be combinational decodes of registered counter state; there SHALL be no added pipeline latency between the counts and the flags.

Reset
REQ-028 While rst_in is 0 at a clock edge, the counters and fc SHALL be loaded with 0, and while rst_in is 0 every output (including ad_out) SHALL be forced to 0.
REQ-029 On the first cycle with rst_in at 1, outputs SHALL be hcount_out=0, vcount_out=0, ad_out=1, and the frame SHALL restart from pixel (0,0) regardless of the position when reset was asserted mid-frame.

Configuration
REQ-030 With macro VIDEO_SIG_GEN_FRAME_COUNT_EN defined, the frame counter of REQ-026 SHALL be compiled in.
REQ-031 Without VIDEO_SIG_GEN_FRAME_COUNT_EN, fc_out SHALL be constant 0, no counter register SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-032 Release reset -> first cycle (0,0) with ad_out=1; cycle 1279 ad_out=1; cycle 1280 ad_out=0.
REQ-033 Run one line -> hs_out high for exactly 40 cycles starting at hcount 1390; at hcount 1649 the next cycle is hcount 0 with vcount 1.
REQ-034 Run full frame -> vs_out high on lines 725..729 only; (1649,749) is followed by (0,0); nf_out high once at (1280,720).
REQ-035 Run 61 frames with the macro defined -> fc_out steps 0..59, then 0, then 1; without the macro -> fc_out stays 0.
REQ-036 Assert rst_in=0 at (500,300) for 3 cycles -> all outputs 0 during reset; the cycle after release is (0,0) with ad_out=1; no nf_out pulse during this sequence.
REQ-037 Override parameters to 8/2/2/2 by 4/1/1/1 -> totals 14x7; hs_out high at hcount 10..11, vs_out high on line 5, nf_out high at (8,4).
